reqresp_wb_bridge: RTL and testbench



---
 rtl/reqresp_wb_bridge.sv | 120 ++++++++++++
 tb/tb_reqresp_wb_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reqresp_wb_bridge.sv
// reqresp_wb_bridge: core request/response port to classic single-transfer Wishbone master.
// Define BRIDGE_TIMEOUT_EN to force-terminate transfers that get no core_ack within TIMEOUT_CYCLES.
module reqresp_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    read_request,
  input  logic                    write_request,
  input  logic [ADDR_WIDTH-1:0]   rw_address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strobe,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_response,
  output logic                    write_response,
  output logic                    core_cyc,
  output logic                    core_stb,
  output logic                    core_we,
  output logic [DATA_WIDTH/8-1:0] core_sel,
  output logic [ADDR_WIDTH-1:0]   core_addr,
  output logic [DATA_WIDTH-1:0]   core_data_out,
  input  logic [DATA_WIDTH-1:0]   core_data_in,
  input  logic                    core_ack,
  output logic                    bus_error
);
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic timeout;
  if (DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("reqresp_wb_bridge: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end
`ifdef BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q;
  // A coincident ack wins over the timeout.
  assign timeout = (state_q == BUS) && !core_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d = (state_q == BUS) ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout;
    end
  end
  assign bus_error = err_q;
`else
  assign timeout = 1'b0;
  assign bus_error = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (write_request) begin
          state_d = BUS;
          we_d    = 1'b1;
          sel_d   = write_strobe;
          addr_d  = rw_address;
          wdata_d = write_data;
        end else if (read_request) begin
          state_d = BUS;
          we_d    = 1'b0;
          sel_d   = '1;
          addr_d  = rw_address;
        end
      end
      BUS: begin
        if (core_ack) begin
          state_d = RESP;
          rdata_d = we_q ? rdata_q : core_data_in;
        end else if (timeout) begin
          state_d = RESP;
          rdata_d = we_q ? rdata_q : '1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign core_cyc       = state_q == BUS;
  assign core_stb       = core_cyc;
  assign core_we        = we_q;
  assign core_sel       = sel_q;
  assign core_addr      = addr_q;
  assign core_data_out  = wdata_q;
  assign read_data      = rdata_q;
  assign read_response  = (state_q == RESP) && !we_q;
  assign write_response = (state_q == RESP) && we_q;
endmodule

// File: tb/tb_reqresp_wb_bridge.sv
// tb_reqresp_wb_bridge: randomized self-checking bench for reqresp_wb_bridge.
module tb_reqresp_wb_bridge;
  logic clk_core = 1'b0;
  logic rst_core;
  logic read_request, write_request;
  logic [31:0] rw_address, write_data, read_data, core_addr, core_data_out, core_data_in;
  logic [3:0] write_strobe, core_sel;
  logic read_response, write_response, core_cyc, core_stb, core_we, core_ack, bus_error;
  int checks = 0;
  int errors = 0;
  logic [31:0] rd_model = '0;

  reqresp_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .read_request(read_request), .write_request(write_request),
    .rw_address(rw_address), .write_data(write_data), .write_strobe(write_strobe),
    .read_data(read_data), .read_response(read_response), .write_response(write_response),
    .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we), .core_sel(core_sel),
    .core_addr(core_addr), .core_data_out(core_data_out), .core_data_in(core_data_in),
    .core_ack(core_ack), .bus_error(bus_error)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  // One complete transfer from an IDLE cycle: ack arrives after `waits` wait cycles.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int waits, input logic [31:0] rdat);
    logic [3:0] esel;
    esel = wr ? s : 4'hF;
    write_request = wr;
    read_request = !wr;
    rw_address = a;
    write_data = d;
    write_strobe = s;
    step();
    for (int i = 0; i <= waits; i++) begin
      if (i == 1) begin
        rw_address = ~a;
        write_data = ~d;
        write_strobe = ~s;
      end
      core_ack = (i == waits);
      core_data_in = (i == waits) ? rdat : $urandom;
      checks++;
      if (core_cyc !== 1'b1 || core_stb !== 1'b1 || core_we !== wr || core_sel !== esel ||
          core_addr !== a || (wr && core_data_out !== d) || read_response !== 1'b0 ||
          write_response !== 1'b0) begin
        errors++;
        $display("FAIL bus_cycle %0d: cyc=%b stb=%b we=%b sel=%h addr=%h dout=%h rr=%b wr=%b, want cyc=1 stb=1 we=%b sel=%h addr=%h dout=%h rr=0 wr=0",
                 i, core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out,
                 read_response, write_response, wr, esel, a, d);
      end
      step();
    end
    core_ack = 1'b0;
    if (!wr) rd_model = rdat;
    checks++;
    if ({core_cyc, read_response, write_response, bus_error} !== {1'b0, !wr, wr, 1'b0}) begin
      errors++;
      $display("FAIL resp: cyc/rr/wr/err=%b%b%b%b want %b%b%b0",
               core_cyc, read_response, write_response, bus_error, 1'b0, !wr, wr);
    end
    checks++;
    if (read_data !== rd_model) begin
      errors++;
      $display("FAIL read_data: got %h want %h", read_data, rd_model);
    end
    read_request = 1'b0;
    write_request = 1'b0;
    step();
    checks++;
    if ({core_cyc, read_response, write_response} !== 3'b000) begin
      errors++;
      $display("FAIL post_resp: cyc/rr/wr=%b%b%b want 000", core_cyc, read_response, write_response);
    end
  endtask

  task automatic test_reset();
    rst_core = 1'b1;
    {read_request, write_request, core_ack} = 3'b000;
    rw_address = '0;
    write_data = '0;
    write_strobe = '0;
    core_data_in = '0;
    step();
    step();
    checks++;
    if ({core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out, read_data,
         read_response, write_response, bus_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cyc=%b we=%b sel=%h addr=%h dout=%h rdata=%h rr=%b wr=%b err=%b, want all 0",
               core_cyc, core_we, core_sel, core_addr, core_data_out, read_data,
               read_response, write_response, bus_error);
    end
    rst_core = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    xfer(1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hA5A5_1234);
  endtask

  task automatic test_write_waits();
    xfer(1'b1, 32'h200, 32'hDEAD_BEEF, 4'h3, 3, 32'h5555_5555);
  endtask

  task automatic test_simultaneous();
    write_request = 1'b1;
    read_request = 1'b1;
    rw_address = 32'h10;
    write_data = 32'h1234_5678;
    write_strobe = 4'hC;
    step();
    core_ack = 1'b1;
    checks++;
    if (core_cyc !== 1'b1 || core_we !== 1'b1 || core_addr !== 32'h10 || core_sel !== 4'hC) begin
      errors++;
      $display("FAIL simul_write_bus: cyc=%b we=%b addr=%h sel=%h want 1 1 00000010 c",
               core_cyc, core_we, core_addr, core_sel);
    end
    step();
    core_ack = 1'b0;
    checks++;
    if ({read_response, write_response} !== 2'b01) begin
      errors++;
      $display("FAIL simul_first_resp: rr/wr=%b%b want 01", read_response, write_response);
    end
    write_request = 1'b0;
    rw_address = 32'h20;
    step();
    checks++;
    if ({core_cyc, read_response, write_response} !== 3'b000) begin
      errors++;
      $display("FAIL simul_gap: cyc/rr/wr=%b%b%b want 000", core_cyc, read_response, write_response);
    end
    step();
    core_ack = 1'b1;
    core_data_in = 32'hCAFE_0020;
    checks++;
    if (core_cyc !== 1'b1 || core_we !== 1'b0 || core_addr !== 32'h20 || core_sel !== 4'hF) begin
      errors++;
      $display("FAIL simul_read_bus: cyc=%b we=%b addr=%h sel=%h want 1 0 00000020 f",
               core_cyc, core_we, core_addr, core_sel);
    end
    step();
    core_ack = 1'b0;
    rd_model = 32'hCAFE_0020;
    checks++;
    if ({read_response, write_response} !== 2'b10 || read_data !== rd_model) begin
      errors++;
      $display("FAIL simul_second_resp: rr/wr=%b%b rdata=%h want 10 %h",
               read_response, write_response, read_data, rd_model);
    end
    read_request = 1'b0;
    step();
  endtask

  task automatic test_spurious_ack();
    core_ack = 1'b1;
    core_data_in = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({core_cyc, read_response, write_response} !== 3'b000 || read_data !== rd_model) begin
        errors++;
        $display("FAIL spurious_ack %0d: cyc/rr/wr=%b%b%b rdata=%h want 000 %h",
                 i, core_cyc, read_response, write_response, read_data, rd_model);
      end
    end
    core_ack = 1'b0;
    xfer(1'b0, 32'h0000_0ABC, 32'h0, 4'h0, 2, 32'h0BAD_F00D);
  endtask

  task automatic test_async_reset();
    write_request = 1'b1;
    rw_address = 32'h300;
    write_data = 32'h1111_2222;
    write_strobe = 4'hF;
    step();
    checks++;
    if (core_cyc !== 1'b1 || core_we !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: cyc=%b we=%b want 1 1", core_cyc, core_we);
    end
    #2 rst_core = 1'b1;
    #1;
    checks++;
    if ({core_cyc, core_stb, core_we} !== 3'b000) begin
      errors++;
      $display("FAIL areset_drop: cyc/stb/we=%b%b%b want 000", core_cyc, core_stb, core_we);
    end
    write_request = 1'b0;
    rd_model = '0;
    step();
    rst_core = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({core_cyc, read_response, write_response} !== 3'b000 || read_data !== rd_model) begin
        errors++;
        $display("FAIL areset_after %0d: cyc/rr/wr=%b%b%b rdata=%h want 000 %h",
                 i, core_cyc, read_response, write_response, read_data, rd_model);
      end
    end
  endtask

  task automatic test_back_to_back();
    xfer(1'b1, 32'h40, 32'h0102_0304, 4'h5, 0, 32'h0);
    xfer(1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h7777_8888);
    xfer(1'b1, 32'h48, 32'h0506_0708, 4'hA, 0, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 5), $urandom);
    end
  endtask

  task automatic test_long_wait();
    xfer(1'b0, 32'h500, 32'h0, 4'h0, 7, 32'h1357_9BDF);
  endtask

`ifdef BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    read_request = 1'b1;
    rw_address = 32'h400;
    core_ack = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (core_cyc !== 1'b1 || read_response !== 1'b0 || bus_error !== 1'b0) begin
        errors++;
        $display("FAIL timeout_bus %0d: cyc=%b rr=%b err=%b want 1 0 0", i, core_cyc, read_response, bus_error);
      end
      step();
    end
    rd_model = 32'hFFFF_FFFF;
    checks++;
    if ({core_cyc, read_response, write_response, bus_error} !== 4'b0101 || read_data !== rd_model) begin
      errors++;
      $display("FAIL timeout_resp: cyc/rr/wr/err=%b%b%b%b rdata=%h want 0101 %h",
               core_cyc, read_response, write_response, bus_error, read_data, rd_model);
    end
    read_request = 1'b0;
    step();
    checks++;
    if ({core_cyc, read_response, bus_error} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_after: cyc/rr/err=%b%b%b want 000", core_cyc, read_response, bus_error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write_waits();
    test_simultaneous();
    test_spurious_ack();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_long_wait();
`ifdef BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
